// File: rtl/cmd_control_param.sv
// SD host CMD controller: frames a command, handshakes with the CMD PHY, captures and checks the response.
// Optional CRC7 response check is enabled by defining CMD_CRC_CHECK_EN (adds the crc_error port).
module cmd_control_param #(
  parameter int ARG_W  = 32,
  parameter int IDX_W  = 6,
  parameter int RESP_W = 128,
  parameter int RX_W   = 136,
  parameter int TO_W   = 16
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     new_command,
  input  logic [ARG_W-1:0]         cmd_argument,
  input  logic [IDX_W-1:0]         cmd_index,
  input  logic [1:0]               resp_type,
  input  logic                     timeout_enable,
  input  logic [TO_W-1:0]          timeout_limit,
  input  logic                     serial_ready,
  input  logic                     ack_in,
  input  logic                     strobe_in,
  input  logic [RX_W-1:0]          cmd_in,
  input  logic                     busy_in,
  output logic [RESP_W-1:0]        response,
  output logic                     command_complete,
  output logic                     command_index_error,
  output logic                     timeout_error,
  output logic                     strobe_out,
  output logic                     ack_out,
  output logic                     idle_out,
  output logic [2+IDX_W+ARG_W-1:0] cmd_out
`ifdef CMD_CRC_CHECK_EN
  ,
  output logic                     crc_error
`endif
);

  localparam int FRAME_W = 2 + IDX_W + ARG_W;

  typedef enum logic [2:0] {IDLE, SETUP, SEND, WAIT_RESP, WAIT_BUSY, ACK, DONE} state_t;

  state_t              state, state_next;
  logic [IDX_W-1:0]    idx_q, idx_next;
  logic [ARG_W-1:0]    arg_q, arg_next;
  logic [1:0]          mode_q, mode_next;
  logic [TO_W-1:0]     counter, counter_next;
  logic [RESP_W-1:0]   response_next;
  logic                idx_err_next, timeout_next, strobe_next;
  logic                ack_next, complete_next, idle_next;
  logic [FRAME_W-1:0]  cmd_out_next;
  logic                short_mode, timed_out, count_en;
  logic                unused_rx;

  // Bits above the long-response field are never delivered to the registers.
  assign unused_rx  = ^cmd_in[RX_W-1:RESP_W];
  assign short_mode = mode_q[0];
  assign timed_out  = timeout_enable && (counter == timeout_limit);
  assign count_en   = timeout_enable && (counter != {TO_W{1'b1}});

`ifdef CMD_CRC_CHECK_EN
  logic crc_next;

  function automatic logic [6:0] crc7(input logic [39:0] data);
    logic [6:0] crc;
    logic       fb;
    crc = 7'd0;
    for (int i = 39; i >= 0; i--) begin
      fb  = data[i] ^ crc[6];
      crc = {crc[5:0], 1'b0};
      if (fb) crc = crc ^ 7'h09;
    end
    return crc;
  endfunction
`endif

  always_comb begin
    state_next    = state;
    idx_next      = idx_q;
    arg_next      = arg_q;
    mode_next     = mode_q;
    counter_next  = counter;
    response_next = response;
    idx_err_next  = command_index_error;
    timeout_next  = timeout_error;
    cmd_out_next  = cmd_out;
    strobe_next   = 1'b0;
`ifdef CMD_CRC_CHECK_EN
    crc_next      = crc_error;
`endif
    case (state)
      IDLE: begin
        if (new_command) begin
          idx_next     = cmd_index;
          arg_next     = cmd_argument;
          mode_next    = resp_type;
          idx_err_next = 1'b0;
          timeout_next = 1'b0;
`ifdef CMD_CRC_CHECK_EN
          crc_next     = 1'b0;
`endif
          state_next   = SETUP;
        end
      end
      SETUP: begin
        cmd_out_next = {1'b0, 1'b1, idx_q, arg_q};
        state_next   = SEND;
      end
      SEND: begin
        if (serial_ready) begin
          strobe_next = 1'b1;
          state_next  = (mode_q == 2'b00) ? ACK : WAIT_RESP;
        end
      end
      WAIT_RESP: begin
        if (count_en) counter_next = counter + TO_W'(1);
        // A response arriving on the timeout cycle takes priority over the timeout.
        if (strobe_in) begin
          response_next = short_mode ? RESP_W'(cmd_in[39:8]) : cmd_in[RESP_W-1:0];
          idx_err_next  = short_mode && (cmd_in[40 +: IDX_W] != idx_q);
`ifdef CMD_CRC_CHECK_EN
          crc_next      = short_mode && (crc7(cmd_in[47:8]) != cmd_in[7:1]);
`endif
          state_next    = (mode_q == 2'b11) ? WAIT_BUSY : ACK;
        end else if (timed_out) begin
          timeout_next = 1'b1;
          state_next   = ACK;
        end
      end
      WAIT_BUSY: begin
        if (count_en) counter_next = counter + TO_W'(1);
        if (!busy_in) begin
          state_next = ACK;
        end else if (timed_out) begin
          timeout_next = 1'b1;
          state_next   = ACK;
        end
      end
      ACK: begin
        if (ack_in) state_next = DONE;
      end
      DONE: begin
        counter_next = '0;
        state_next   = IDLE;
      end
      default: state_next = IDLE;
    endcase
    ack_next      = (state_next == ACK);
    complete_next = (state_next == DONE);
    idle_next     = (state_next == IDLE);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state               <= IDLE;
      idx_q               <= '0;
      arg_q               <= '0;
      mode_q              <= 2'b00;
      counter             <= '0;
      response            <= '0;
      command_index_error <= 1'b0;
      timeout_error       <= 1'b0;
      cmd_out             <= '0;
      strobe_out          <= 1'b0;
      ack_out             <= 1'b0;
      command_complete    <= 1'b0;
      idle_out            <= 1'b1;
`ifdef CMD_CRC_CHECK_EN
      crc_error           <= 1'b0;
`endif
    end else begin
      state               <= state_next;
      idx_q               <= idx_next;
      arg_q               <= arg_next;
      mode_q              <= mode_next;
      counter             <= counter_next;
      response            <= response_next;
      command_index_error <= idx_err_next;
      timeout_error       <= timeout_next;
      cmd_out             <= cmd_out_next;
      strobe_out          <= strobe_next;
      ack_out             <= ack_next;
      command_complete    <= complete_next;
      idle_out            <= idle_next;
`ifdef CMD_CRC_CHECK_EN
      crc_error           <= crc_next;
`endif
    end
  end

endmodule

// File: tb/tb_cmd_control_param.sv
// Testbench for cmd_control_param: directed and randomized commands against a transaction-level model.
module tb_cmd_control_param;

  logic         clock, reset, new_command;
  logic [31:0]  cmd_argument;
  logic [5:0]   cmd_index;
  logic [1:0]   resp_type;
  logic         timeout_enable;
  logic [15:0]  timeout_limit;
  logic         serial_ready, ack_in, strobe_in, busy_in;
  logic [135:0] cmd_in;
  logic [127:0] response;
  logic         command_complete, command_index_error, timeout_error;
  logic         strobe_out, ack_out, idle_out;
  logic [39:0]  cmd_out;
`ifdef CMD_CRC_CHECK_EN
  logic         crc_error;
`endif

  int checks = 0;
  int errors = 0;
  int strobe_total = 0;
  int done_total = 0;
  logic [127:0] model_resp = '0;

  cmd_control_param dut (
    .clock(clock), .reset(reset), .new_command(new_command),
    .cmd_argument(cmd_argument), .cmd_index(cmd_index), .resp_type(resp_type),
    .timeout_enable(timeout_enable), .timeout_limit(timeout_limit),
    .serial_ready(serial_ready), .ack_in(ack_in), .strobe_in(strobe_in),
    .cmd_in(cmd_in), .busy_in(busy_in), .response(response),
    .command_complete(command_complete), .command_index_error(command_index_error),
    .timeout_error(timeout_error), .strobe_out(strobe_out), .ack_out(ack_out),
    .idle_out(idle_out), .cmd_out(cmd_out)
`ifdef CMD_CRC_CHECK_EN
    , .crc_error(crc_error)
`endif
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // Pulse counters let each transaction verify exactly one strobe and one completion.
  always @(negedge clock) begin
    if (strobe_out) strobe_total <= strobe_total + 1;
    if (command_complete) done_total <= done_total + 1;
  end

  function automatic logic [6:0] ref_crc7(input logic [39:0] data);
    logic [46:0] rem;
    rem = {data, 7'b0};
    for (int i = 46; i >= 7; i--)
      if (rem[i]) rem[i -: 8] = rem[i -: 8] ^ 8'h89;
    return rem[6:0];
  endfunction

  function automatic logic [135:0] rand_rx();
    return {8'($urandom()), $urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  task automatic checkOutput(input string tag, input logic [135:0] obs, input logic [135:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One full command: d = WAIT_RESP cycle carrying strobe_in (-1 = never), b = busy cycles after it.
  task automatic applyStimulus(input logic [5:0] idx, input logic [31:0] arg, input logic [1:0] mode,
                               input logic to_en, input logic [15:0] lim, input int d, input int b,
                               input logic [135:0] rx, input int ack_dly);
    logic captured, short_m, exp_to, exp_ierr, exp_crc, got;
    logic [127:0] exp_resp;
    int s0, c0, lat, limv;
    limv     = int'(lim);
    short_m  = mode[0];
    captured = (mode != 2'b00) && (d >= 0) && !(to_en && d > limv);
    exp_to   = (mode != 2'b00) && to_en &&
               (d < 0 || d > limv || (mode == 2'b11 && limv >= d + 1 && limv <= d + b));
    exp_ierr = captured && short_m && (rx[45:40] != idx);
    exp_crc  = captured && short_m && (ref_crc7(rx[47:8]) != rx[7:1]);
    exp_resp = !captured ? model_resp : (short_m ? {96'b0, rx[39:8]} : rx[127:0]);
    model_resp = exp_resp;
    s0 = strobe_total;
    c0 = done_total;
    @(negedge clock);
    new_command = 1'b1; cmd_index = idx; cmd_argument = arg; resp_type = mode;
    timeout_enable = to_en; timeout_limit = lim; serial_ready = 1'b0;
    @(negedge clock);
    new_command = 1'b0; cmd_index = ~idx; cmd_argument = $urandom(); resp_type = ~mode;
    repeat ($urandom_range(0, 3)) @(negedge clock);
    serial_ready = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clock);
      got = strobe_out;
    end
    checkOutput("strobe_seen", 136'(got), 136'(1));
    checkOutput("frame", 136'(cmd_out), 136'({2'b01, idx, arg}));
    serial_ready = 1'b0;
    lat = 0;
    if (mode != 2'b00 && d >= 0) begin
      repeat (d) begin @(negedge clock); lat++; end
      strobe_in = 1'b1; cmd_in = rx; busy_in = (mode == 2'b11);
      @(negedge clock);
      lat++;
      strobe_in = 1'b0; cmd_in = rand_rx();
      if (mode == 2'b11)
        for (int j = 0; j < b; j++) begin
          busy_in = 1'b1;
          if (!exp_to) checkOutput("busy_hold", 136'(ack_out), 136'(0));
          @(negedge clock);
        end
      busy_in = 1'b0;
    end
    for (int i = 0; i < 300 && !ack_out; i++) begin @(negedge clock); lat++; end
    checkOutput("ack_seen", 136'(ack_out), 136'(1));
    if (mode == 2'b00) checkOutput("ack_latency", 136'(lat), 136'(0));
    else if (d < 0) checkOutput("timeout_latency", 136'(lat), 136'(limv + 1));
    repeat (ack_dly) begin
      @(negedge clock);
      checkOutput("ack_hold", 136'(ack_out), 136'(1));
    end
    ack_in = 1'b1;
    @(negedge clock);
    ack_in = 1'b0;
    checkOutput("complete_pulse", 136'(command_complete), 136'(1));
    checkOutput("ack_drop", 136'(ack_out), 136'(0));
    @(negedge clock);
    checkOutput("complete_end", 136'(command_complete), 136'(0));
    checkOutput("idle_back", 136'(idle_out), 136'(1));
    checkOutput("response", 136'(response), 136'(exp_resp));
    checkOutput("index_error", 136'(command_index_error), 136'(exp_ierr));
    checkOutput("timeout_error", 136'(timeout_error), 136'(exp_to));
`ifdef CMD_CRC_CHECK_EN
    checkOutput("crc_error", 136'(crc_error), 136'(exp_crc));
`else
    if (exp_crc) model_resp = exp_resp;
`endif
    checkOutput("strobe_count", 136'(strobe_total - s0), 136'(1));
    checkOutput("complete_count", 136'(done_total - c0), 136'(1));
  endtask

  initial begin
    logic [1:0]   mode;
    logic [5:0]   idx;
    logic [31:0]  arg;
    logic         to_en;
    logic [15:0]  lim;
    logic [135:0] rx;
    int           d, b, c0;
    logic         got;

    reset = 1'b1; new_command = 1'b0; cmd_argument = '0; cmd_index = '0; resp_type = 2'b00;
    timeout_enable = 1'b0; timeout_limit = '0; serial_ready = 1'b0; ack_in = 1'b0;
    strobe_in = 1'b0; cmd_in = '0; busy_in = 1'b0;
    repeat (3) @(negedge clock);
    checkOutput("rst_idle", 136'(idle_out), 136'(1));
    checkOutput("rst_response", 136'(response), 136'(0));
    checkOutput("rst_cmd_out", 136'(cmd_out), 136'(0));
    checkOutput("rst_flags", 136'({command_complete, command_index_error, timeout_error, strobe_out, ack_out}), 136'(0));
    reset = 1'b0;

    applyStimulus(6'h11, 32'hDEADBEEF, 2'b00, 1'b0, 16'd0, 0, 0, '0, 2);
    applyStimulus(6'h11, 32'h00000001, 2'b01, 1'b0, 16'd0, 3, 0, {88'b0, 48'h11_12345678_A5}, 0);
    applyStimulus(6'h11, 32'h00000002, 2'b01, 1'b0, 16'd0, 1, 0, {88'b0, 48'h12_12345678_A5}, 1);
    applyStimulus(6'h02, 32'hCAFEF00D, 2'b10, 1'b0, 16'd0, 4, 0, {8'hFF, 128'h0123456789ABCDEF0123456789ABCDEF}, 0);
    applyStimulus(6'h11, 32'h0, 2'b01, 1'b1, 16'd10, -1, 0, '0, 0);
    applyStimulus(6'h11, 32'h0, 2'b01, 1'b0, 16'd10, 30, 0, rand_rx(), 0);
    applyStimulus(6'h11, 32'h0, 2'b01, 1'b1, 16'd10, 10, 0, rand_rx(), 0);
    applyStimulus(6'h11, 32'h0, 2'b01, 1'b1, 16'd10, 11, 0, rand_rx(), 0);
    applyStimulus(6'h05, 32'h0, 2'b01, 1'b1, 16'd0, -1, 0, '0, 0);
    applyStimulus(6'h07, 32'h12, 2'b11, 1'b0, 16'd0, 2, 5, {88'b0, 48'h07_AABBCCDD_01}, 0);
    applyStimulus(6'h07, 32'h13, 2'b11, 1'b1, 16'd8, 2, 10, {88'b0, 48'h07_AABBCCDD_01}, 1);

    for (int t = 0; t < 25; t++) begin
      mode  = 2'($urandom_range(0, 3));
      idx   = 6'($urandom());
      arg   = $urandom();
      to_en = 1'($urandom_range(0, 1));
      lim   = 16'($urandom_range(0, 15));
      d     = to_en ? int'($urandom_range(0, 21)) - 1 : int'($urandom_range(0, 20));
      b     = int'($urandom_range(0, 6));
      rx    = rand_rx();
      if ($urandom_range(0, 1) == 1) rx[45:40] = idx;
      applyStimulus(idx, arg, mode, to_en, lim, d, b, rx, int'($urandom_range(0, 3)));
    end

    // Reset while waiting for a response must abort silently.
    @(negedge clock);
    new_command = 1'b1; cmd_index = 6'h21; cmd_argument = 32'h55; resp_type = 2'b01;
    timeout_enable = 1'b0; serial_ready = 1'b1;
    @(negedge clock);
    new_command = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clock);
      got = strobe_out;
    end
    checkOutput("mid_strobe_seen", 136'(got), 136'(1));
    serial_ready = 1'b0;
    repeat (3) @(negedge clock);
    c0 = done_total;
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    checkOutput("mid_rst_idle", 136'(idle_out), 136'(1));
    checkOutput("mid_rst_flags", 136'({command_complete, command_index_error, timeout_error, strobe_out, ack_out}), 136'(0));
    checkOutput("mid_rst_response", 136'(response), 136'(0));
    model_resp = '0;
    repeat (5) @(negedge clock);
    checkOutput("mid_rst_no_complete", 136'(done_total - c0), 136'(0));
    checkOutput("mid_rst_still_idle", 136'(idle_out), 136'(1));

    applyStimulus(6'h09, 32'h77, 2'b10, 1'b1, 16'd12, 5, 0, rand_rx(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/cmd_control_param.md
Name: cmd_control_param

Overview:
Parametrised next-generation SD host CMD controller. Sits between the register/Wishbone side and the CMD physical layer.
- Builds the 48-bit command frame (start, transmission, index, argument).
- Drives the strobe/ack handshake with the physical layer.
- Supports none/short/long/short-with-busy response modes, a programmable internal timeout counter, and response index checking.
- Reports completion and error flags to the registers.

Parameters:
ARG_W, 32, command argument width (frame payload bits [ARG_W-1:0])
IDX_W, 6, command index width
RESP_W, 128, response bits delivered to registers
RX_W, 136, raw response width from physical layer (must be >= RESP_W+8)
TO_W, 16, timeout counter width

Ports:
clock  in  1  system clock
reset  in  1  synchronous active-high reset
new_command  in  1  start pulse from registers/WB
cmd_argument  in  ARG_W  command argument
cmd_index  in  IDX_W  command index
resp_type  in  2  00 none, 01 short(48), 10 long(136), 11 short+busy
timeout_enable  in  1  enable internal timeout
timeout_limit  in  TO_W  cycles allowed in WAIT_RESP
serial_ready  in  1  physical layer ready to accept frame
ack_in  in  1  physical layer acknowledges ack_out
strobe_in  in  1  physical layer done; cmd_in valid
cmd_in  in  RX_W  received response, right-aligned
busy_in  in  1  DAT0 busy indication (mode 11)
response  out  RESP_W  captured response
command_complete  out  1  completion flag (1 cycle)
command_index_error  out  1  response index mismatch
timeout_error  out  1  no response within timeout_limit
strobe_out  out  1  request physical layer transfer
ack_out  out  1  acknowledge strobe_in
idle_out  out  1  physical layer to idle
cmd_out  out  2+IDX_W+ARG_W  frame: {1'b0,1'b1,cmd_index,cmd_argument}

Behaviour:
- All outputs are registered. Reset (sync, active-high) overrides everything and lands in IDLE: response=0, all flags=0, strobe_out=0, ack_out=0, cmd_out=0, idle_out=1, timeout counter=0.
- Reset asserted mid-operation aborts at the next edge: no command_complete is produced and no error flags are set.
- States: IDLE, SETUP, SEND, WAIT_RESP, WAIT_BUSY, ACK, DONE.
- IDLE:
  - idle_out=1.
  - new_command=1 latches cmd_index, cmd_argument and resp_type, then goes to SETUP.
  - new_command while not in IDLE is ignored.
- SETUP:
  - cmd_out loaded with the frame; idle_out=0; goes to SEND.
- SEND:
  - Waits for serial_ready=1, then asserts strobe_out for exactly 1 cycle.
  - Next state is WAIT_RESP, or ACK if resp_type=00.
- WAIT_RESP:
  - The counter increments each cycle while timeout_enable=1.
  - strobe_in=1:
    - Capture response. Short: response = cmd_in[39:8], zero-extended. Long: response = cmd_in[RESP_W-1:0].
    - Short modes: command_index_error = (cmd_in[45:40] != latched index).
    - Go to WAIT_BUSY if mode 11, else ACK.
  - counter == timeout_limit with timeout_enable=1: timeout_error=1, go to ACK.
  - strobe_in and timeout on the same cycle: strobe_in wins and timeout_error stays 0.
  - timeout_limit=0 with timeout_enable=1 times out on the first WAIT_RESP cycle if strobe_in=0.
- WAIT_BUSY:
  - Waits for busy_in=0, also subject to the timeout. The counter continues from its WAIT_RESP value, not reset.
  - Then goes to ACK.
- ACK:
  - ack_out=1, held until ack_in=1, then DONE.
- DONE:
  - command_complete=1 for exactly 1 cycle; ack_out=0; counter cleared; back to IDLE.
- Error flags hold until the next new_command is accepted, which clears them. response holds until the next capture.
- Counter saturates at all-ones and does not wrap.

Optional Feature:
- Macro CMD_CRC_CHECK_EN.
- Defined:
  - Adds output crc_error (1 bit, reset 0).
  - On short-response capture, computes CRC7 (poly x^7+x^3+1) over cmd_in[47:8] and compares it with cmd_in[7:1]; a mismatch sets crc_error.
  - Long responses are not checked (crc_error=0).
  - crc_error clears with the other flags.
- Undefined: no crc_error port and no CRC logic.

Test Plan:
- Reset then new_command, idx=6'h11, arg=32'hDEADBEEF, mode 00, serial_ready=1 -> cmd_out=40'h51DEADBEEF, one strobe_out pulse, ack_out until ack_in, command_complete pulse, no response capture.
- Mode 01, idx 6'h11, cmd_in[47:0]=48'h11_12345678_xx -> response=32'h12345678, command_index_error=0. Repeat with cmd_in[45:40]=6'h12 -> command_index_error=1.
- Mode 10, cmd_in[127:0]=128'h0123...CDEF -> response equals it after ACK, command_complete=1.
- Mode 01, timeout_enable=1, limit=16'd10, no strobe_in -> timeout_error=1 after 10 WAIT_RESP cycles. With timeout_enable=0 the block waits indefinitely. strobe_in on cycle 10 -> timeout_error=0.
- Mode 11, busy_in high 5 cycles after strobe_in -> command_complete only after busy_in falls.
- Reset asserted during WAIT_RESP -> next cycle in IDLE, idle_out=1, all flags 0, no command_complete.
